// File: rtl/idct_transpose_buffer_pkg.sv
// Shared constants, bank-state encoding and addressing helper for the IDCT
// transpose buffer.
package idct_transpose_buffer_pkg;

  localparam int IDCT_DATA_WIDTH = 16;
  localparam int IDCT_BLOCK_SIZE = 64;
  localparam int IDCT_PTR_WIDTH  = $clog2(IDCT_BLOCK_SIZE);
  localparam int IDCT_RAM_AWIDTH = IDCT_PTR_WIDTH + 1;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'b00,
    BANK_FILLING = 2'b01,
    BANK_FULL    = 2'b10
  } bank_state_e;

  typedef logic [IDCT_PTR_WIDTH-1:0] ptr_t;

  localparam ptr_t PTR_LAST = ptr_t'(IDCT_BLOCK_SIZE - 1);

  // Element k of the column-major replay lives at row k[2:0], col k[5:3].
  function automatic ptr_t col_major_addr(input ptr_t rp);
    return {rp[2:0], rp[5:3]};
  endfunction

endpackage

// File: rtl/idct_transpose_ram.sv
// Two-bank 64-entry RAM: one write port, one registered read port,
// addressed as {bank, offset}.
module idct_transpose_ram
  import idct_transpose_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = IDCT_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rd_clear,
  input  logic                       wr_en,
  input  logic [IDCT_RAM_AWIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  input  logic [IDCT_RAM_AWIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]      rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:2*IDCT_BLOCK_SIZE-1];

  // NOTE: the array is never reset so it can map onto block RAM; only the
  // read register clears, which is what the outside world observes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register holds its value whenever rd_en is low.
  always_ff @(posedge clk) begin
    if (rd_clear) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/idct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer: raster-order writes, column-major replay.
// Optional input saturation to CLIP_WIDTH bits when IDCT_TRANSPOSE_SAT_EN is defined.
module idct_transpose_buffer
  import idct_transpose_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = IDCT_DATA_WIDTH,
  parameter int CLIP_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last
);

`ifdef IDCT_TRANSPOSE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'((2 ** (CLIP_WIDTH - 1)) - 1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(-(2 ** (CLIP_WIDTH - 1)));

  bank_state_e bank_state [2];
  bank_state_e bank_next  [2];

  logic                  clear;
  logic                  wr_bank;
  logic                  rd_bank;
  ptr_t                  wp;
  ptr_t                  rp;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  rd_en;
  logic                  rd_sel;
  ptr_t                  rd_elem;
  logic [DATA_WIDTH-1:0] store_data;

  assign clear    = reset | flush;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Saturation is pure combinational logic in front of the write port.
  always_comb begin
    store_data = in_data;
    if (SAT_EN) begin
      if ($signed(in_data) > SAT_MAX) begin
        store_data = SAT_MAX;
      end else if ($signed(in_data) < SAT_MIN) begin
        store_data = SAT_MIN;
      end
    end
  end

  // Bank state register.
  // NOTE: reset here is synchronous, so it lives inside the clocked block and
  // flush shares the same path with priority over every transfer.
  always_ff @(posedge clk) begin
    if (clear) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
    end else begin
      bank_state[0] <= bank_next[0];
      bank_state[1] <= bank_next[1];
    end
  end

  // Bank next-state: a bank only leaves FULL on the transfer of its last element.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_next[b] = bank_state[b];
      unique case (bank_state[b])
        BANK_EMPTY: begin
          if (in_xfer && (wr_bank == 1'(b))) begin
            bank_next[b] = BANK_FILLING;
          end
        end
        BANK_FILLING: begin
          if (in_xfer && (wr_bank == 1'(b)) && (wp == PTR_LAST)) begin
            bank_next[b] = BANK_FULL;
          end
        end
        BANK_FULL: begin
          if (out_xfer && (rd_bank == 1'(b)) && (rp == PTR_LAST)) begin
            bank_next[b] = BANK_EMPTY;
          end
        end
        default: bank_next[b] = BANK_EMPTY;
      endcase
    end
  end

  // Outputs derived from registered state only, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = (bank_state[wr_bank] != BANK_FULL);
    out_first = out_valid && (rp == '0);
    out_last  = out_valid && (rp == PTR_LAST);
  end

  // Read issue: rp names the element in the output register, so the RAM is
  // always fetching the element after it.
  // NOTE: every signal gets a default before the branches; without them this
  // block would infer latches.
  always_comb begin
    rd_en   = 1'b0;
    rd_sel  = rd_bank;
    rd_elem = rp;
    if (!out_valid) begin
      rd_en = (bank_state[rd_bank] == BANK_FULL);
    end else if (out_ready) begin
      if (rp != PTR_LAST) begin
        rd_en   = 1'b1;
        rd_elem = rp + 1'b1;
      end else if (bank_state[~rd_bank] == BANK_FULL) begin
        rd_en   = 1'b1;
        rd_sel  = ~rd_bank;
        rd_elem = '0;
      end
    end
  end

  // Pointers, bank selects and output valid.
  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (clear) begin
      wp        <= '0;
      rp        <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_xfer) begin
        wp <= wp + 1'b1;
        if (wp == PTR_LAST) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (out_xfer) begin
        rp <= rp + 1'b1;
        if (rp == PTR_LAST) begin
          rd_bank <= ~rd_bank;
        end
      end
      if (rd_en) begin
        out_valid <= 1'b1;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  idct_transpose_ram #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk      (clk),
    .rd_clear (clear),
    .wr_en    (in_xfer & ~clear),
    .wr_addr  ({wr_bank, wp}),
    .wr_data  (store_data),
    .rd_en    (rd_en & ~clear),
    .rd_addr  ({rd_sel, col_major_addr(rd_elem)}),
    .rd_data  (out_data)
  );

endmodule

// File: tb/tb_idct_transpose_buffer.sv
// Self-checking bench for idct_transpose_buffer: directed tables plus a
// queue-based transpose model that checks every output transfer.
module tb_idct_transpose_buffer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;

  idct_transpose_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          first;
    logic          last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          first;
    logic          last;
    int            cyc;
  } obs_t;

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          first;
    logic          last;
  } vec_t;

  typedef struct {
    logic [DW-1:0] din;
    int            pos;
    logic [DW-1:0] dout;
  } sat_vec_t;

  int            n_vec = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            acc_total = 0;
  int            last_acc_cyc = 0;
  int            stalls = 0;
  logic [DW-1:0] in_q[$];
  beat_t         exp_q[$];
  obs_t          obs_q[$];
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  beat_t         mon_b;
  obs_t          mon_o;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // What the buffer should store for a given input sample.
  function automatic logic [DW-1:0] model_store(input logic [DW-1:0] v);
`ifdef IDCT_TRANSPOSE_SAT_EN
    int s;
    s = int'($signed(v));
    if (s > 2047) return DW'(2047);
    if (s < -2048) return DW'(-2048);
`endif
    return v;
  endfunction

  // Reference model: collect 64 accepted samples, then emit them column by column.
  always @(negedge clk) begin
    if (reset || flush) begin
      in_q.delete();
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (in_valid && in_ready) begin
        in_q.push_back(model_store(in_data));
        acc_total++;
        last_acc_cyc = cyc;
        if (in_q.size() == 64) begin
          for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
              mon_b.data  = in_q[r * 8 + c];
              mon_b.first = (r == 0) && (c == 0);
              mon_b.last  = (r == 7) && (c == 7);
              exp_q.push_back(mon_b);
            end
          end
          in_q.delete();
        end
      end
      if (out_valid && out_ready) begin
        mon_o.data  = out_data;
        mon_o.first = out_first;
        mon_o.last  = out_last;
        mon_o.cyc   = cyc;
        obs_q.push_back(mon_o);
        if (exp_q.size() == 0) begin
          check("spurious_output", 32'(out_valid), 32'd0);
        end else begin
          mon_b = exp_q.pop_front();
          check("model_data", 32'(out_data), 32'(mon_b.data));
          check("model_first", 32'(out_first), 32'(mon_b.first));
          check("model_last", 32'(out_last), 32'(mon_b.last));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one sample until accepted, bounded.
  task automatic send(input logic [DW-1:0] v);
    bit ok;
    int budget;
    ok      = 1'b0;
    budget  = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (!ok && budget < 2000) begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) stalls++;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!ok) check("send_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_obs(input int n, input int budget);
    int b;
    b = 0;
    while (obs_q.size() < n && b < budget) begin
      step(1);
      b++;
    end
    if (obs_q.size() < n) check("obs_timeout", 32'(obs_q.size()), 32'(n));
  endtask

  vec_t     tbl[64];
  sat_vec_t sat_tbl[3];
  int       acc_base;
  int       n_seen;

  initial begin
    for (int i = 0; i < 64; i++) begin
      tbl[i].din   = DW'(i);
      tbl[i].dout  = DW'((i % 8) * 8 + i / 8);
      tbl[i].first = (i == 0);
      tbl[i].last  = (i == 63);
    end
    sat_tbl[0] = '{din: DW'(3000),  pos: 0,  dout: DW'(3000)};
    sat_tbl[1] = '{din: DW'(-3000), pos: 8,  dout: DW'(-3000)};
    sat_tbl[2] = '{din: DW'(100),   pos: 16, dout: DW'(100)};
`ifdef IDCT_TRANSPOSE_SAT_EN
    sat_tbl[0].dout = DW'(2047);
    sat_tbl[1].dout = DW'(-2048);
`endif

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_first", 32'(out_first), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // Single block, table driven.
    obs_q.delete();
    for (int i = 0; i < 64; i++) send(tbl[i].din);
    in_valid = 1'b0;
    wait_obs(64, 300);
    if (obs_q.size() >= 64) begin
      for (int i = 0; i < 64; i++) begin
        check("blk_data", 32'(obs_q[i].data), 32'(tbl[i].dout));
        check("blk_first", 32'(obs_q[i].first), 32'(tbl[i].first));
        check("blk_last", 32'(obs_q[i].last), 32'(tbl[i].last));
      end
      check("blk_latency", 32'(obs_q[0].cyc - last_acc_cyc), 32'd2);
      check("blk_no_bubble", 32'(obs_q[63].cyc - obs_q[0].cyc), 32'd63);
    end

    // Back-to-back streaming.
    step(5);
    obs_q.delete();
    stalls = 0;
    for (int i = 0; i < 128; i++) send(DW'(i));
    in_valid = 1'b0;
    check("b2b_in_stalls", 32'(stalls), 32'd0);
    wait_obs(128, 400);
    if (obs_q.size() >= 128) begin
      check("b2b_no_bubble", 32'(obs_q[127].cyc - obs_q[0].cyc), 32'd127);
      check("b2b_blk2_first", 32'(obs_q[64].data), 32'd64);
      check("b2b_blk2_flag", 32'(obs_q[64].first), 32'd1);
      check("b2b_blk2_second", 32'(obs_q[65].data), 32'd72);
      check("b2b_blk2_last", 32'(obs_q[127].data), 32'd127);
    end

    // Backpressure with three blocks offered.
    step(5);
    obs_q.delete();
    out_ready = 1'b0;
    acc_base  = acc_total;
    fork
      begin
        for (int i = 0; i < 192; i++) send(DW'(i));
        in_valid = 1'b0;
      end
      begin
        int b;
        b = 0;
        while ((acc_total - acc_base) < 128 && b < 1000) begin
          step(1);
          b++;
        end
        step(6);
        check("bp_accepted", 32'(acc_total - acc_base), 32'd128);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_data", 32'(out_data), 32'd0);
        check("bp_out_first", 32'(out_first), 32'd1);
        out_ready = 1'b1;
      end
    join
    wait_obs(192, 600);
    if (obs_q.size() >= 192) begin
      check("bp_blk1", 32'(obs_q[0].data), 32'd0);
      check("bp_blk2", 32'(obs_q[64].data), 32'd64);
      check("bp_blk3", 32'(obs_q[128].data), 32'd128);
      check("bp_blk3_last", 32'(obs_q[191].data), 32'd191);
    end

    // Flush part-way through a block.
    step(5);
    obs_q.delete();
    for (int i = 0; i < 30; i++) send(DW'(i));
    in_data  = DW'(30);
    in_valid = 1'b1;
    flush    = 1'b1;
    step(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    step(80);
    check("flush_no_out", 32'(obs_q.size()), 32'd0);
    for (int i = 0; i < 64; i++) send(DW'(100 + i));
    in_valid = 1'b0;
    wait_obs(64, 300);
    if (obs_q.size() >= 64) begin
      check("flush_first_data", 32'(obs_q[0].data), 32'd100);
      check("flush_first_flag", 32'(obs_q[0].first), 32'd1);
      check("flush_second", 32'(obs_q[1].data), 32'd108);
    end

    // Reset during a drain.
    step(5);
    obs_q.delete();
    for (int i = 0; i < 64; i++) send(DW'(200 + i));
    in_valid = 1'b0;
    wait_obs(20, 300);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rdr_in_ready", 32'(in_ready), 32'd1);
    check("rdr_out_valid", 32'(out_valid), 32'd0);
    n_seen = obs_q.size();
    step(20);
    check("rdr_outputs_stop", 32'(obs_q.size()), 32'(n_seen));
    obs_q.delete();
    for (int i = 0; i < 64; i++) send(DW'(300 + i));
    in_valid = 1'b0;
    wait_obs(64, 300);
    if (obs_q.size() >= 64) begin
      check("rdr_new_first", 32'(obs_q[0].data), 32'd300);
      check("rdr_new_flag", 32'(obs_q[0].first), 32'd1);
      check("rdr_new_last", 32'(obs_q[63].data), 32'd363);
      check("rdr_new_lflag", 32'(obs_q[63].last), 32'd1);
    end

    // Saturation boundary values (stored unmodified without the macro).
    step(5);
    obs_q.delete();
    for (int i = 0; i < 64; i++) begin
      if (i < 3) send(sat_tbl[i].din);
      else       send(DW'(i));
    end
    in_valid = 1'b0;
    wait_obs(64, 300);
    if (obs_q.size() >= 64) begin
      for (int k = 0; k < 3; k++) begin
        check("sat_value", 32'(obs_q[sat_tbl[k].pos].data), 32'(sat_tbl[k].dout));
      end
    end

    // Random traffic with random backpressure.
    step(5);
    obs_q.delete();
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            step(1);
          end
          send(DW'($urandom));
        end
        in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 700; t++) begin
          out_ready = ($urandom_range(3) != 0);
          step(1);
        end
        out_ready = 1'b1;
      end
    join
    wait_obs(256, 600);
    step(5);
    check("model_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/idct_transpose_buffer.md
Name: idct_transpose_buffer

Overview:
- Ping-pong 8x8 transpose memory between the row pass and the column pass of the 2-D IDCT.
- Accepts row-pass results in raster order (row-major, one coefficient per cycle).
- Replays each block column-major to the column pass, which feeds multiplier3/multiplier1.
- Two banks: one block is written while the previous block drains.

Parameters:
- DATA_WIDTH, 16, sample width (equals IDCT_DATA_WIDTH), two's complement.
- CLIP_WIDTH, 12, saturation width; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_WIDTH  row-pass sample, raster order
- in_valid  in  1  in_data valid
- in_ready  out  1  buffer can accept in_data this cycle
- out_data  out  DATA_WIDTH  sample to column pass, column-major order
- out_valid  out  1  out_data valid
- out_ready  in  1  column pass accepts out_data
- out_first  out  1  out_data is element (row 0, col 0) of a block
- out_last  out  1  out_data is element (row 7, col 7) of a block
- flush  in  1  synchronous abort: discards all buffered data, same effect as reset

Behaviour:
- Clock and reset: one clock domain, clk; reset is synchronous and active-high, named reset.
- Reset values: in_ready=1 (in the cycle after reset deasserts), out_valid=0, out_first=0, out_last=0, out_data=0.
  - Both banks go EMPTY; write and read pointers go to 0; write bank and read bank select go to 0.
- Transfers: input transfer = in_valid&in_ready; output transfer = out_valid&out_ready. No combinational path from out_ready to in_ready.
- Per-bank state machine: EMPTY -> FILLING on the first write; FILLING -> FULL on the 64th write; FULL -> EMPTY when the 64th output transfer completes.
- Write pointer wp[5:0]: address = wp (row=wp[5:3], col=wp[2:0]). It increments per input transfer and wraps 63->0. On wrap the write bank select toggles.
- in_ready=1 iff the current write bank is EMPTY or FILLING.
- Read pointer rp[5:0]: bank address = {rp[2:0], rp[5:3]}. This emits col 0 rows 0..7, then col 1, and so on. It advances per output transfer and wraps 63->0; on wrap the read bank select toggles.
- Memory: synchronous-read RAM, 2x64xDATA_WIDTH, plus one output holding register.
  - out_data/out_valid are registered.
  - out_data is stable while out_valid=1 and out_ready=0.
- Latency: the first output of a block is valid 2 cycles after the cycle of its 64th input transfer, provided the read side is idle. Sustained throughput is 1 sample/cycle on both sides.
- out_first=1 with rp element 0; out_last=1 with rp element 63. Both are qualified by out_valid.
- Simultaneous events:
  - Filling bank A while draining bank B is legal.
  - A write to a bank in the same cycle it goes FULL->EMPTY is not accepted; in_ready for that bank rises the next cycle.
- Both banks FULL: in_ready=0 until a drain completes.
- Reset or flush mid-block: the partial block is discarded, no output is produced, and all state returns to reset values on the next cycle. flush has priority over simultaneous transfers.

Optional Feature:
- Macro: IDCT_TRANSPOSE_SAT_EN.
- Defined: in_data is saturated to the signed CLIP_WIDTH range [-2^(CLIP_WIDTH-1), 2^(CLIP_WIDTH-1)-1] before storage, and sign-extended to DATA_WIDTH. Saturation adds no cycles.
- Not defined: in_data is stored unmodified. CLIP_WIDTH is unused.

Decomposition:
- Shared defines.v:
  - IDCT_DATA_WIDTH
  - IDCT_BLOCK_SIZE=64
  - bank-state encodings: EMPTY=2'b00, FILLING=2'b01, FULL=2'b10
- One sub-module: idct_transpose_ram, a dual-port 2x64 synchronous RAM (one write port, one read port, 7-bit addresses {bank, addr}). It is separate so it can map to block RAM.

Test Plan:
- Single block: 64 inputs with values 0..63, out_ready=1.
  - Outputs are 0,8,16,...,56,1,9,...,63.
  - out_first is set on value 0 and out_last on value 63.
  - First out_valid occurs 2 cycles after the last input.
- Back-to-back streaming: blocks of base 0 then base 64, both sides continuous.
  - in_ready stays 1 throughout.
  - Second-block outputs are 64,72,...,127 with no bubbles.
- Backpressure: out_ready=0 while 3 blocks are offered.
  - in_ready drops after input 128.
  - out_data holds 0 stable.
  - Releasing out_ready drains blocks 1, 2, 3 in order.
- flush at input 30 of block 1.
  - No outputs appear.
  - The next 64 inputs 100..163 give outputs 100,108,... with out_first on 100.
- Reset asserted during a drain at output 20: outputs stop, in_ready=1, and a new block drains correctly from element 0.
- SAT (with the macro defined): inputs 3000, -3000 and 100 give stored/output values 2047, -2048 and 100. Without the macro they give 3000, -3000 and 100.
